// File: rtl/if_id_pipe_if.sv
// rtl/if_id_pipe_if.sv - valid/ready instruction beat bus (PC + instruction)
// The producer drives valid/pc/inst, the consumer drives ready.
interface if_id_pipe_if #(
   parameter int PC_W   = 32,
   parameter int INST_W = 32
);
   logic              valid;
   logic              ready;
   logic [PC_W-1:0]   pc;
   logic [INST_W-1:0] inst;

   modport master (output valid, output pc, output inst, input ready);
   modport slave  (input valid, input pc, input inst, output ready);
endinterface

// File: rtl/if_id_pipe.sv
// rtl/if_id_pipe.sv - IF->ID stage buffer: in-order FIFO with flush, kill window and NOP bubbles
// Fetch side is a slave bus, decode side a master bus; empty slots present NOP_INST at PC 0.
module if_id_pipe #(
   parameter int                PC_W     = 32,
   parameter int                INST_W   = 32,
   parameter int                DEPTH    = 2,
   parameter int                KILL_CNT = 1,
   parameter logic [INST_W-1:0] NOP_INST = 32'h00000013
) (
   input  logic                       clk,
   input  logic                       rst,
   if_id_pipe_if.slave                if_bus,
   if_id_pipe_if.master               id_bus,
   input  logic                       flush_i,
   output logic                       flush_pending_o,
   output logic [$clog2(DEPTH+1)-1:0] occupancy_o
);
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int OCC_W = $clog2(DEPTH + 1);
   localparam logic [OCC_W-1:0] FULL     = OCC_W'(DEPTH);
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

   logic [PC_W-1:0]   pc_mem_q   [DEPTH];
   logic [INST_W-1:0] inst_mem_q [DEPTH];
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [OCC_W-1:0]  occ_q, occ_d;
   logic [1:0]        kill_q, kill_d;
   logic              pend_q, pend_d;

   logic if_ready, id_valid, if_hs, deq, enq;

   // Ready depends on registered occupancy only: no pass-through when full.
   assign if_ready = (occ_q != FULL);
   assign id_valid = (occ_q != '0);
   assign if_hs    = if_bus.valid & if_ready;
   assign deq      = id_valid & id_bus.ready;
   assign enq      = if_hs & ~flush_i & (kill_q == 2'd0);

   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      occ_d    = occ_q;
      kill_d   = kill_q;
      pend_d   = pend_q;
      if (flush_i) begin
         // Flush beats enqueue, dequeue and kill decrement alike.
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         occ_d    = '0;
         kill_d   = 2'(KILL_CNT);
         pend_d   = 1'b1;
      end else begin
         if (deq) rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
         if (enq) wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
         occ_d = occ_q + OCC_W'(enq) - OCC_W'(deq);
         if (if_hs && kill_q != 2'd0) kill_d = kill_q - 2'd1;
         if (enq) pend_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         occ_q    <= '0;
         kill_q   <= 2'd0;
         pend_q   <= 1'b0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         occ_q    <= occ_d;
         kill_q   <= kill_d;
         pend_q   <= pend_d;
      end
   end

   // Storage needs no reset: occupancy alone decides what is visible.
   always_ff @(posedge clk) begin
      if (enq) begin
         pc_mem_q[wr_ptr_q]   <= if_bus.pc;
         inst_mem_q[wr_ptr_q] <= if_bus.inst;
      end
   end

   assign if_bus.ready    = if_ready;
   assign id_bus.valid    = id_valid;
   assign id_bus.pc       = id_valid ? pc_mem_q[rd_ptr_q] : '0;
   assign id_bus.inst     = id_valid ? inst_mem_q[rd_ptr_q] : NOP_INST;
   assign flush_pending_o = pend_q;
   assign occupancy_o     = occ_q;
endmodule

// File: tb/tb_if_id_pipe.sv
// tb/tb_if_id_pipe.sv - bench for if_id_pipe: two configurations against a list-based model
// DUT0: DEPTH=2 KILL_CNT=1, DUT1: DEPTH=3 KILL_CNT=2, sharing fetch stimulus.
module tb_if_id_pipe;
   localparam logic [31:0] NOP = 32'h00000013;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        valid = 1'b0;
   logic        flush = 1'b0;
   logic        rdy0 = 1'b0;
   logic        rdy1 = 1'b0;
   logic [31:0] pc = '0;
   logic [31:0] inst = '0;
   logic        fp0, fp1;
   logic [1:0]  occ0, occ1;

   int checks = 0;
   int errors = 0;

   if_id_pipe_if #(.PC_W(32), .INST_W(32)) f0 ();
   if_id_pipe_if #(.PC_W(32), .INST_W(32)) d0 ();
   if_id_pipe_if #(.PC_W(32), .INST_W(32)) f1 ();
   if_id_pipe_if #(.PC_W(32), .INST_W(32)) d1 ();

   assign f0.valid = valid;
   assign f0.pc    = pc;
   assign f0.inst  = inst;
   assign d0.ready = rdy0;
   assign f1.valid = valid;
   assign f1.pc    = pc;
   assign f1.inst  = inst;
   assign d1.ready = rdy1;

   if_id_pipe #(.DEPTH(2), .KILL_CNT(1)) u_dut0 (
      .clk(clk), .rst(rst), .if_bus(f0), .id_bus(d0),
      .flush_i(flush), .flush_pending_o(fp0), .occupancy_o(occ0)
   );
   if_id_pipe #(.DEPTH(3), .KILL_CNT(2)) u_dut1 (
      .clk(clk), .rst(rst), .if_bus(f1), .id_bus(d1),
      .flush_i(flush), .flush_pending_o(fp1), .occupancy_o(occ1)
   );

   always #5 clk = ~clk;

   // Model: an ordered list of buffered beats per DUT, head at index 0.
   int          n [2];
   int          kill [2];
   bit          pend [2];
   logic [31:0] mpc [2][8];
   logic [31:0] minst [2][8];
   int          dep [2] = '{2, 3};
   int          kc [2]  = '{1, 2};

   task automatic mreset(int k);
      n[k] = 0;
      kill[k] = 0;
      pend[k] = 1'b0;
   endtask

   task automatic mstep(int k, bit r);
      bit hs, dq;
      hs = valid && (n[k] < dep[k]);
      dq = (n[k] != 0) && r;
      if (flush) begin
         n[k] = 0;
         kill[k] = kc[k];
         pend[k] = 1'b1;
      end else begin
         if (dq) begin
            for (int i = 0; i < 7; i++) begin
               mpc[k][i] = mpc[k][i+1];
               minst[k][i] = minst[k][i+1];
            end
            n[k] = n[k] - 1;
         end
         if (hs) begin
            if (kill[k] > 0) kill[k] = kill[k] - 1;
            else begin
               mpc[k][n[k]] = pc;
               minst[k][n[k]] = inst;
               n[k] = n[k] + 1;
               pend[k] = 1'b0;
            end
         end
      end
   endtask

   // Compare on the falling edge, then advance the model for the coming rising edge.
   initial begin
      logic [70:0] act, exp;
      forever begin
         @(negedge clk);
         for (int k = 0; k < 2; k++) begin
            if (!rst) mreset(k);
            if (k == 0) act = {d0.valid, f0.ready, fp0, 2'b00, occ0, d0.pc, d0.inst};
            else        act = {d1.valid, f1.ready, fp1, 2'b00, occ1, d1.pc, d1.inst};
            exp = {n[k] != 0, n[k] < dep[k], pend[k], 4'(n[k]),
                   (n[k] != 0) ? mpc[k][0] : 32'h0, (n[k] != 0) ? minst[k][0] : NOP};
            checks++;
            if (act !== exp) begin
               errors++;
               $display("FAIL model_cmp dut%0d t=%0t got %h expected %h", k, $time, act, exp);
            end
            if (rst) mstep(k, (k == 0) ? rdy0 : rdy1);
         end
      end
   end

   task automatic chk(string name, logic [63:0] a, logic [63:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s t=%0t got %h expected %h", name, $time, a, e);
      end
   endtask

   task automatic cyc(bit v, logic [31:0] p, bit f, bit r);
      valid = v;
      pc = p;
      inst = $urandom;
      flush = f;
      rdy0 = r;
      rdy1 = r;
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [31:0] pcv;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid", 64'(d0.valid), 64'd0);
      chk("rst_inst", 64'(d0.inst), 64'(NOP));
      chk("rst_pc", 64'(d0.pc), 64'd0);
      chk("rst_ready", 64'(f0.ready), 64'd1);
      chk("rst_occ", 64'(occ0), 64'd0);
      chk("rst_inst1", 64'(d1.inst), 64'(NOP));
      rst = 1'b1;

      cyc(1, 32'h00, 0, 1);
      chk("stream_pc0", 64'(d0.pc), 64'h00);
      chk("stream_occ", 64'(occ0), 64'd1);
      cyc(1, 32'h04, 0, 1);
      chk("stream_pc4", 64'(d0.pc), 64'h04);
      cyc(1, 32'h08, 0, 1);
      chk("stream_pc8", 64'(d0.pc), 64'h08);
      cyc(0, 32'h0, 0, 1);
      chk("stream_empty", 64'(d0.valid), 64'd0);

      cyc(1, 32'h10, 0, 0);
      cyc(1, 32'h14, 0, 0);
      chk("bp_occ", 64'(occ0), 64'd2);
      chk("bp_ready", 64'(f0.ready), 64'd0);
      chk("bp_head", 64'(d0.pc), 64'h10);
      cyc(0, 32'h0, 0, 0);
      chk("bp_hold", 64'(d0.pc), 64'h10);
      cyc(0, 32'h0, 0, 1);
      chk("bp_second", 64'(d0.pc), 64'h14);
      chk("bp_ready_back", 64'(f0.ready), 64'd1);
      cyc(0, 32'h0, 0, 1);
      chk("bp_drained", 64'(d0.valid), 64'd0);

      cyc(1, 32'h18, 0, 0);
      cyc(1, 32'h1c, 0, 0);
      chk("fl_pre_occ", 64'(occ0), 64'd2);
      cyc(1, 32'h20, 1, 0);
      chk("fl_occ", 64'(occ0), 64'd0);
      chk("fl_pend", 64'(fp0), 64'd1);
      cyc(1, 32'h24, 0, 0);
      chk("fl_kill_occ", 64'(occ0), 64'd0);
      chk("fl_kill_pend", 64'(fp0), 64'd1);
      cyc(1, 32'h80, 0, 0);
      chk("fl_new_pend", 64'(fp0), 64'd0);
      chk("fl_new_pc", 64'(d0.pc), 64'h80);
      repeat (3) cyc(0, 32'h0, 0, 1);

      cyc(1, 32'h30, 0, 1);
      chk("fl2_head", 64'(d0.pc), 64'h30);
      cyc(1, 32'h34, 1, 1);
      chk("fl2_deq_occ", 64'(occ0), 64'd0);
      cyc(1, 32'h38, 1, 1);
      chk("fl2_pend", 64'(fp0), 64'd1);
      cyc(1, 32'h40, 0, 1);
      chk("fl2_kill", 64'(occ0), 64'd0);
      cyc(1, 32'h44, 0, 1);
      chk("fl2_pc", 64'(d0.pc), 64'h44);
      chk("fl2_pend_clr", 64'(fp0), 64'd0);
      repeat (3) cyc(0, 32'h0, 0, 1);

      cyc(1, 32'h50, 0, 0);
      cyc(1, 32'h54, 0, 0);
      chk("ar_pre_occ", 64'(occ0), 64'd2);
      valid = 1'b0;
      #2 rst = 1'b0;
      #1;
      chk("ar_valid", 64'(d0.valid), 64'd0);
      chk("ar_occ", 64'(occ0), 64'd0);
      chk("ar_pc", 64'(d0.pc), 64'd0);
      chk("ar_inst", 64'(d0.inst), 64'(NOP));
      chk("ar_ready", 64'(f0.ready), 64'd1);
      @(posedge clk);
      #1 rst = 1'b1;

      pcv = 32'h1000;
      for (int i = 0; i < 400; i++) begin
         valid = ($urandom_range(0, 9) < 7);
         pcv = pcv + 32'd4;
         pc = pcv;
         inst = $urandom;
         flush = ($urandom_range(0, 29) == 0);
         rdy0 = ($urandom_range(0, 2) != 0);
         rdy1 = ($urandom_range(0, 1) != 0);
         @(posedge clk);
         #1;
      end
      repeat (5) cyc(0, 32'h0, 0, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
